// File: rtl/fp_pkg.sv
// Shared floating-point definitions: FP32 defaults, bias, special-value builders, class codes, flag indices.
// FP_MULT_RNE_EN widens the kept mantissa product so guard/sticky bits survive into rounding.
package fp_pkg;

    localparam int FP32_EXP_W = 8;
    localparam int FP32_MAN_W = 23;
    localparam int FP_MAX_W   = 64;

    localparam int FLAG_W   = 3;
    localparam int FLAG_INV = 2;
    localparam int FLAG_OVF = 1;
    localparam int FLAG_UDF = 0;

    typedef enum logic [1:0] {
        CLS_ZERO = 2'd0,
        CLS_NORM = 2'd1,
        CLS_INF  = 2'd2,
        CLS_NAN  = 2'd3
    } fp_class_e;

    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Truncation only needs the hidden bit, the possible normalisation bit and the fraction.
    function automatic int fp_prod_keep_w(input int man_w);
`ifdef FP_MULT_RNE_EN
        return 2 * (man_w + 1);
`else
        return man_w + 2;
`endif
    endfunction

    function automatic logic [FP_MAX_W-1:0] fp_qnan(input int exp_w, input int man_w);
        logic [FP_MAX_W-1:0] v;
        v = '0;
        for (int i = 0; i < exp_w; i++) v[man_w + i] = 1'b1;
        v[man_w - 1] = 1'b1;
        return v;
    endfunction

    function automatic logic [FP_MAX_W-1:0] fp_inf(input logic sign, input int exp_w, input int man_w);
        logic [FP_MAX_W-1:0] v;
        v = '0;
        for (int i = 0; i < exp_w; i++) v[man_w + i] = 1'b1;
        v[exp_w + man_w] = sign;
        return v;
    endfunction

    function automatic logic [FP_MAX_W-1:0] fp_zero(input logic sign, input int exp_w, input int man_w);
        logic [FP_MAX_W-1:0] v;
        v = '0;
        v[exp_w + man_w] = sign;
        return v;
    endfunction

endpackage

// File: rtl/fp_normalize_round.sv
// Combinational normalize, round (RNE when FP_MULT_RNE_EN, else truncate) and pack with overflow/underflow saturation.
// Zero latency; no handshake, the caller registers the result.
module fp_normalize_round
    import fp_pkg::*;
#(
    parameter int EXP_W  = FP32_EXP_W,
    parameter int MAN_W  = FP32_MAN_W,
    parameter int PROD_W = fp_prod_keep_w(MAN_W)
) (
    input  logic                    sign_i,
    input  logic signed [EXP_W+1:0] exp_i,
    input  logic [PROD_W-1:0]       prod_i,
    output logic [EXP_W+MAN_W:0]    res_o,
    output logic                    ovf_o,
    output logic                    udf_o
);

    localparam logic signed [EXP_W+1:0] E_ONE  = (EXP_W+2)'(1);
    localparam logic signed [EXP_W+1:0] E_ZERO = '0;
    localparam logic signed [EXP_W+1:0] E_MAX  = (EXP_W+2)'((1 << EXP_W) - 1);

    logic                    msb;
    logic signed [EXP_W+1:0] exp_n;
    logic signed [EXP_W+1:0] exp_r;
    logic [MAN_W-1:0]        frac_t;
    logic [MAN_W:0]          man_r;
    logic                    rnd_up;
`ifdef FP_MULT_RNE_EN
    logic                    guard;
    logic                    sticky;
`endif

    always_comb begin
        msb    = prod_i[PROD_W-1];
        exp_n  = msb ? exp_i + E_ONE : exp_i;
        frac_t = msb ? prod_i[PROD_W-2 -: MAN_W] : prod_i[PROD_W-3 -: MAN_W];
`ifdef FP_MULT_RNE_EN
        guard  = msb ? prod_i[PROD_W-2-MAN_W] : prod_i[PROD_W-3-MAN_W];
        sticky = msb ? |prod_i[PROD_W-3-MAN_W:0] : |prod_i[PROD_W-4-MAN_W:0];
        rnd_up = guard && (sticky || frac_t[0]);
`else
        rnd_up = 1'b0;
`endif
        // A carry out means 1.11..1 rounded up to 10.00..0: fraction is already zero.
        man_r = {1'b0, frac_t} + {{MAN_W{1'b0}}, rnd_up};
        exp_r = man_r[MAN_W] ? exp_n + E_ONE : exp_n;
        ovf_o = (exp_r >= E_MAX);
        udf_o = (exp_r <= E_ZERO);
        res_o = {sign_i, exp_r[EXP_W-1:0], man_r[MAN_W-1:0]};
        if (ovf_o) begin
            res_o = {sign_i, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (udf_o) begin
            res_o = {sign_i, {(EXP_W+MAN_W){1'b0}}};
        end
    end

endmodule

// File: rtl/fp_mult_pipe.sv
// 3-stage pipelined FP multiplier (unpack, mantissa product, normalize/round/pack), 3-cycle latency, 1/cycle.
// Global stall: all stages hold while out_valid && !out_ready; FP_MULT_RNE_EN selects RNE, default truncates.
module fp_mult_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = FP32_EXP_W,
    parameter int MAN_W = FP32_MAN_W,
    parameter int TAG_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] in_a,
    input  logic [EXP_W+MAN_W:0] in_b,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] out_p,
    output logic [TAG_W-1:0]     out_tag,
    output logic [FLAG_W-1:0]    out_flags
);

    localparam int W      = 1 + EXP_W + MAN_W;
    localparam int PW     = 2 * (MAN_W + 1);
    localparam int KEEP_W = fp_prod_keep_w(MAN_W);
    localparam logic signed [EXP_W+1:0] BIAS_S    = (EXP_W+2)'(fp_bias(EXP_W));
    localparam logic [FP_MAX_W-1:0]     QNAN_FULL = fp_qnan(EXP_W, MAN_W);
    localparam logic [FP_MAX_W-1:0]     INF_FULL  = fp_inf(1'b0, EXP_W, MAN_W);
    localparam logic [FP_MAX_W-1:0]     ZERO_FULL = fp_zero(1'b0, EXP_W, MAN_W);

    logic                    adv;
    logic                    sign_a, sign_b;
    logic [EXP_W-1:0]        exp_a, exp_b;
    logic [MAN_W-1:0]        frac_a, frac_b;
    fp_class_e               cls_a, cls_b;
    logic                    inf_zero, snan;

    logic                    v1_q, v2_q, v3_q;
    logic                    sign1_d, sign1_q, sign2_q;
    fp_class_e               cls1_d, cls1_q, cls2_q;
    logic                    inv1_d, inv1_q, inv2_q;
    logic signed [EXP_W+1:0] exp1_d, exp1_q, exp2_q;
    logic [MAN_W:0]          man_a1_q, man_b1_q;
    logic [KEEP_W-1:0]       prod2_d, prod2_q;
    logic [TAG_W-1:0]        tag1_q, tag2_q, tag3_q;
    logic [W-1:0]            p3_d, p3_q;
    logic [FLAG_W-1:0]       flags3_d, flags3_q;
    logic [W-1:0]            nr_res;
    logic                    nr_ovf, nr_udf;

    assign adv       = !v3_q || out_ready;
    assign in_ready  = adv;
    assign out_valid = v3_q;
    assign out_p     = p3_q;
    assign out_tag   = tag3_q;
    assign out_flags = flags3_q;

    assign {sign_a, exp_a, frac_a} = in_a;
    assign {sign_b, exp_b, frac_b} = in_b;

    always_comb begin
        cls_a = CLS_NORM;
        if (exp_a == '0)  cls_a = CLS_ZERO;
        else if (&exp_a)  cls_a = (frac_a == '0) ? CLS_INF : CLS_NAN;
        cls_b = CLS_NORM;
        if (exp_b == '0)  cls_b = CLS_ZERO;
        else if (&exp_b)  cls_b = (frac_b == '0) ? CLS_INF : CLS_NAN;

        inf_zero = (cls_a == CLS_INF && cls_b == CLS_ZERO) || (cls_a == CLS_ZERO && cls_b == CLS_INF);
        snan     = (cls_a == CLS_NAN && !frac_a[MAN_W-1]) || (cls_b == CLS_NAN && !frac_b[MAN_W-1]);

        // Result class resolved up front so later stages only carry the winner.
        cls1_d = CLS_NORM;
        if (cls_a == CLS_NAN || cls_b == CLS_NAN || inf_zero) cls1_d = CLS_NAN;
        else if (cls_a == CLS_INF || cls_b == CLS_INF)        cls1_d = CLS_INF;
        else if (cls_a == CLS_ZERO || cls_b == CLS_ZERO)      cls1_d = CLS_ZERO;

        inv1_d  = inf_zero || snan;
        sign1_d = sign_a ^ sign_b;
        exp1_d  = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - BIAS_S;
    end

    assign prod2_d = KEEP_W'((PW'(man_a1_q) * PW'(man_b1_q)) >> (PW - KEEP_W));

    fp_normalize_round #(
        .EXP_W  (EXP_W),
        .MAN_W  (MAN_W),
        .PROD_W (KEEP_W)
    ) u_norm (
        .sign_i (sign2_q),
        .exp_i  (exp2_q),
        .prod_i (prod2_q),
        .res_o  (nr_res),
        .ovf_o  (nr_ovf),
        .udf_o  (nr_udf)
    );

    always_comb begin
        p3_d     = nr_res;
        flags3_d = '0;
        case (cls2_q)
            CLS_NAN: begin
                p3_d               = QNAN_FULL[W-1:0];
                flags3_d[FLAG_INV] = inv2_q;
            end
            CLS_INF:  p3_d = {sign2_q, INF_FULL[W-2:0]};
            CLS_ZERO: p3_d = {sign2_q, ZERO_FULL[W-2:0]};
            default: begin
                flags3_d[FLAG_OVF] = nr_ovf;
                flags3_d[FLAG_UDF] = nr_udf;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            v3_q     <= 1'b0;
            sign1_q  <= 1'b0;
            sign2_q  <= 1'b0;
            cls1_q   <= CLS_ZERO;
            cls2_q   <= CLS_ZERO;
            inv1_q   <= 1'b0;
            inv2_q   <= 1'b0;
            exp1_q   <= '0;
            exp2_q   <= '0;
            man_a1_q <= '0;
            man_b1_q <= '0;
            prod2_q  <= '0;
            tag1_q   <= '0;
            tag2_q   <= '0;
            tag3_q   <= '0;
            p3_q     <= '0;
            flags3_q <= '0;
        end else if (adv) begin
            v1_q     <= in_valid;
            sign1_q  <= sign1_d;
            cls1_q   <= cls1_d;
            inv1_q   <= inv1_d;
            exp1_q   <= exp1_d;
            man_a1_q <= {1'b1, frac_a};
            man_b1_q <= {1'b1, frac_b};
            tag1_q   <= in_tag;
            v2_q     <= v1_q;
            sign2_q  <= sign1_q;
            cls2_q   <= cls1_q;
            inv2_q   <= inv1_q;
            exp2_q   <= exp1_q;
            prod2_q  <= prod2_d;
            tag2_q   <= tag1_q;
            v3_q     <= v2_q;
            p3_q     <= p3_d;
            tag3_q   <= tag2_q;
            flags3_q <= flags3_d;
        end
    end

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Scoreboarded bench for fp_mult_pipe (FP32): vectors, specials, range, backpressure and mid-flight reset.
module tb_fp_mult_pipe;

    typedef struct packed {
        logic [31:0] p;
        logic [7:0]  tag;
        logic [2:0]  flags;
    } exp_t;

`ifdef FP_MULT_RNE_EN
    localparam logic [31:0] RND_EXP = 32'h3FC00002;
`else
    localparam logic [31:0] RND_EXP = 32'h3FC00001;
`endif

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [7:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_p;
    logic [7:0]  out_tag;
    logic [2:0]  out_flags;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    fp_mult_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .out_tag   (out_tag),
        .out_flags (out_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, checks %0d/%0d", n_pass, n_checks);
        $fatal(1, "timeout");
    end

    // Inputs are driven at posedge+1; handshakes are sampled at posedge+2 and take effect at the next edge.
    task automatic step(output logic acc, output logic xfer, output logic vld, output logic rdy, output exp_t seen);
        #1;
        acc  = in_valid && in_ready;
        xfer = out_valid && out_ready;
        vld  = out_valid;
        rdy  = in_ready;
        seen = exp_t'({out_p, out_tag, out_flags});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", out_valid); else n_pass++;
        n_checks++; if (out_p !== 32'h0) $display("FAIL rst_p: got %h want 00000000", out_p); else n_pass++;
        n_checks++; if (out_tag !== 8'h0) $display("FAIL rst_tag: got %h want 00", out_tag); else n_pass++;
        n_checks++; if (out_flags !== 3'b000) $display("FAIL rst_flags: got %b want 000", out_flags); else n_pass++;
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b want 1", in_ready); else n_pass++;
    endtask

    task automatic test_vectors();
        logic [31:0] va [12];
        logic [31:0] vb [12];
        logic [31:0] vp [12];
        logic [2:0]  vf [12];
        logic        acc, xfer, vld, rdy;
        logic [7:0]  tag;
        exp_t        seen, want;
        int          lat;
        va = '{32'h3FC00000, 32'h40400000, 32'h3F800001, 32'h7F800000, 32'hFF800000, 32'h80000000,
               32'h00000001, 32'h7F000000, 32'h00800000, 32'h7FC00000, 32'h7F800001, 32'hC0400000};
        vb = '{32'h40000000, 32'h40400000, 32'h3FC00000, 32'h00000000, 32'h40000000, 32'h3F800000,
               32'h3F800000, 32'h7F000000, 32'h00800000, 32'h3F800000, 32'h3F800000, 32'h40000000};
        vp = '{32'h40400000, 32'h41100000, RND_EXP,      32'h7FC00000, 32'hFF800000, 32'h80000000,
               32'h00000000, 32'h7F800000, 32'h00000000, 32'h7FC00000, 32'h7FC00000, 32'hC0C00000};
        vf = '{3'b000, 3'b000, 3'b000, 3'b100, 3'b000, 3'b000,
               3'b000, 3'b010, 3'b001, 3'b000, 3'b100, 3'b000};
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tag      = (i == 0) ? 8'h11 : 8'(32'h40 + i);
            in_valid = 1'b1;
            in_a     = va[i];
            in_b     = vb[i];
            in_tag   = tag;
            step(acc, xfer, vld, rdy, seen);
            in_valid = 1'b0;
            n_checks++; if (acc !== 1'b1) $display("FAIL vec%0d_accept: got %b want 1", i, acc); else n_pass++;
            if (acc) exp_q.push_back(exp_t'({vp[i], tag, vf[i]}));
            lat  = 0;
            xfer = 1'b0;
            while (!xfer && lat < 10) begin
                step(acc, xfer, vld, rdy, seen);
                lat++;
            end
            n_checks++; if (lat !== 3) $display("FAIL vec%0d_latency: got %0d want 3", i, lat); else n_pass++;
            if (xfer && exp_q.size() > 0) begin
                want = exp_q.pop_front();
                n_checks++; if (seen.p !== want.p) $display("FAIL vec%0d_p: got %h want %h", i, seen.p, want.p); else n_pass++;
                n_checks++; if (seen.tag !== want.tag) $display("FAIL vec%0d_tag: got %h want %h", i, seen.tag, want.tag); else n_pass++;
                n_checks++; if (seen.flags !== want.flags) $display("FAIL vec%0d_flags: got %b want %b", i, seen.flags, want.flags); else n_pass++;
            end else begin
                n_checks++; $display("FAIL vec%0d_output: got none want one result", i);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic acc, xfer, vld, rdy;
        exp_t seen, want;
        int   sent = 0, got = 0, stall_left = 4, cyc = 0, extra = 0;
        logic saw_first = 1'b0, saw_low = 1'b0;
        exp_q.delete();
        out_ready = 1'b1;
        while (got < 5 && cyc < 60) begin
            if (sent < 5) begin
                in_valid = 1'b1;
                in_a     = 32'h3F800000 + 32'(sent) * 32'h00100000;
                in_b     = 32'h40000000;
                in_tag   = 8'(32'h20 + sent);
            end else begin
                in_valid = 1'b0;
            end
            if (out_valid) saw_first = 1'b1;
            out_ready = !(saw_first && stall_left > 0);
            if (!out_ready) stall_left--;
            step(acc, xfer, vld, rdy, seen);
            cyc++;
            if (!rdy) saw_low = 1'b1;
            if (acc) begin
                exp_q.push_back(exp_t'({in_a + 32'h00800000, in_tag, 3'b000}));
                sent++;
            end
            if (vld && !xfer) begin
                n_checks++;
                if ({out_valid, out_p, out_tag, out_flags} !== {1'b1, seen})
                    $display("FAIL b2b_hold: got %b/%h/%h want 1/%h/%h", out_valid, out_p, out_tag, seen.p, seen.tag);
                else n_pass++;
            end
            if (xfer) begin
                got++;
                if (exp_q.size() == 0) begin
                    n_checks++; $display("FAIL b2b_extra: got %h tag %h want no result", seen.p, seen.tag);
                end else begin
                    want = exp_q.pop_front();
                    n_checks++; if (seen.p !== want.p) $display("FAIL b2b_p%0d: got %h want %h", got, seen.p, want.p); else n_pass++;
                    n_checks++; if (seen.tag !== want.tag) $display("FAIL b2b_tag%0d: got %h want %h", got, seen.tag, want.tag); else n_pass++;
                    n_checks++; if (seen.flags !== want.flags) $display("FAIL b2b_flags%0d: got %b want %b", got, seen.flags, want.flags); else n_pass++;
                end
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n_checks++; if (got !== 5) $display("FAIL b2b_count: got %0d want 5", got); else n_pass++;
        n_checks++; if (saw_low !== 1'b1) $display("FAIL b2b_in_ready_drop: got %b want 1", saw_low); else n_pass++;
        n_checks++; if (stall_left !== 0) $display("FAIL b2b_stall_cycles: got %0d left want 0", stall_left); else n_pass++;
        for (int k = 0; k < 6; k++) begin
            step(acc, xfer, vld, rdy, seen);
            if (vld) extra++;
        end
        n_checks++; if (extra !== 0) $display("FAIL b2b_duplicate: got %0d extra want 0", extra); else n_pass++;
        n_checks++; if (exp_q.size() !== 0) $display("FAIL b2b_lost: got %0d pending want 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_reset_midflight();
        logic acc, xfer, vld, rdy;
        exp_t seen, want;
        int   stale = 0, lat;
        exp_q.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_a     = 32'h3FC00000;
            in_b     = 32'h40000000;
            in_tag   = 8'(32'h50 + i);
            step(acc, xfer, vld, rdy, seen);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst       = 1'b1;
        step(acc, xfer, vld, rdy, seen);
        rst       = 1'b0;
        out_ready = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL mid_rst_valid: got %b want 0", out_valid); else n_pass++;
        n_checks++; if (out_p !== 32'h0) $display("FAIL mid_rst_p: got %h want 00000000", out_p); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL mid_rst_in_ready: got %b want 1", in_ready); else n_pass++;
        for (int k = 0; k < 5; k++) begin
            step(acc, xfer, vld, rdy, seen);
            if (vld) stale++;
        end
        n_checks++; if (stale !== 0) $display("FAIL mid_rst_stale: got %0d results want 0", stale); else n_pass++;
        in_valid = 1'b1;
        in_a     = 32'h40400000;
        in_b     = 32'h40400000;
        in_tag   = 8'h77;
        step(acc, xfer, vld, rdy, seen);
        in_valid = 1'b0;
        if (acc) exp_q.push_back(exp_t'({32'h41100000, 8'h77, 3'b000}));
        lat  = 0;
        xfer = 1'b0;
        while (!xfer && lat < 10) begin
            step(acc, xfer, vld, rdy, seen);
            lat++;
        end
        n_checks++; if (lat !== 3) $display("FAIL mid_new_latency: got %0d want 3", lat); else n_pass++;
        if (xfer && exp_q.size() > 0) begin
            want = exp_q.pop_front();
            n_checks++; if (seen.p !== want.p) $display("FAIL mid_new_p: got %h want %h", seen.p, want.p); else n_pass++;
            n_checks++; if (seen.tag !== want.tag) $display("FAIL mid_new_tag: got %h want %h", seen.tag, want.tag); else n_pass++;
        end else begin
            n_checks++; $display("FAIL mid_new_output: got none want one result");
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        test_reset();
        test_vectors();
        test_back_to_back();
        test_reset_midflight();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fp_mult_pipe.md
Name: fp_mult_pipe

Overview:
Parametrised, 3-stage pipelined IEEE-754-style floating-point multiplier with valid/ready handshake. It is the next generation of the processing-element multiplier in the systolic FP32 matrix engine. Improvements over the single-cycle combinational multiplier:
- configurable exponent and mantissa widths
- correct bias handling
- special-value handling (zero, inf, NaN)
- overflow and underflow saturation
- a sideband tag carried alongside each operand pair

Parameters:
- EXP_W, 8: exponent field width; bias = 2^(EXP_W-1)-1.
- MAN_W, 23: stored fraction width; hidden bit is implicit.
- TAG_W, 8: sideband tag width, passed through unchanged (PE row/col id).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept this cycle
- in_a  in  1+EXP_W+MAN_W  operand A {sign, exp, frac}
- in_b  in  1+EXP_W+MAN_W  operand B
- in_tag  in  TAG_W  sideband tag
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_p  out  1+EXP_W+MAN_W  product
- out_tag  out  TAG_W  tag of the product
- out_flags  out  3  {invalid, overflow, underflow}

Behaviour:
- Clocking: one clock domain (clk). rst is synchronous, active-high.
- Reset values: all stage valid bits 0, out_valid 0, out_p 0, out_tag 0, out_flags 0. rst asserted mid-operation discards all in-flight data; in_ready is 1 on the cycle after rst deasserts.
- Pipeline control: global stall. adv = !out_valid || out_ready, and in_ready = adv.
  - A transfer occurs when in_valid && in_ready.
  - All stage registers, including valid bits, load only when adv=1.
  - Latency is 3 cycles from accept to out_valid with no stall. Throughput is 1 per cycle.
  - While out_valid && !out_ready, out_p, out_tag and out_flags are held stable.
- S1 (unpack):
  - Sign = sA^sB.
  - Classify each operand: zero/denormal (exp=0, flushed to zero), inf (exp all-ones, frac=0), NaN (exp all-ones, frac!=0).
  - Compute signed exponent sum e = eA + eB - bias, width EXP_W+2.
  - Form mantissas {1, frac}.
- S2: unsigned product of the two MAN_W+1-bit mantissas, width 2*(MAN_W+1).
- S3 (normalize, round, pack):
  - If the product MSB is 1, shift right 1 and set e+1.
  - Take the fraction from the next MAN_W bits. Guard = next bit; sticky = OR of all remaining bits.
  - Round per the optional feature. A rounding carry out of the mantissa renormalises and sets e+1.
- Special-case priority, highest first:
  1. Any NaN, or inf*zero: canonical qNaN (sign 0, exp all-ones, frac MSB 1, rest 0). invalid=1 only for inf*zero or a signalling NaN input.
  2. Any inf: signed inf.
  3. Any zero: signed zero.
  4. Final e >= 2^EXP_W-1: signed inf, overflow=1.
  5. Final e <= 0: signed zero, underflow=1 (no denormal outputs).
- Flags accompany their own result only; they are not sticky.

Optional Feature:
- Macro: FP_MULT_RNE_EN.
- Defined: round-to-nearest-even. Round up when guard && (sticky || lsb).
- Undefined: truncation, matching legacy PE numerics; guard and sticky logic is omitted.
- Latency, special-case handling and the handshake are identical in both builds.

Decomposition:
- Shared package fp_pkg:
  - FP32 defaults (EXP_W=8, MAN_W=23)
  - bias function
  - canonical qNaN / inf / zero constant builders
  - class encoding localparams (ZERO, NORM, INF, NAN)
  - flag bit indices
- One natural sub-module, fp_normalize_round: S3 combinational normalize, round and pack, with parameters EXP_W and MAN_W. It is reused later by the FP adder.
- The mantissa product is a plain width-parametrised multiply inside S2.

Test Plan:
- Basic: A=0x3FC00000 (1.5), B=0x40000000 (2.0), tag=0x11 -> out_p=0x40400000, out_tag=0x11, flags=0, out_valid exactly 3 cycles after accept. A=0x40400000 (3.0), B=0x40400000 -> 0x41100000.
- Rounding: A=0x3F800001, B=0x3FC00000 -> 0x3FC00002 with FP_MULT_RNE_EN (tie, odd lsb rounds up); 0x3FC00001 without it.
- Specials:
  - 0x7F800000 * 0x00000000 -> 0x7FC00000, invalid=1.
  - 0xFF800000 * 0x40000000 -> 0xFF800000, flags=0.
  - 0x80000000 * 0x3F800000 -> 0x80000000.
  - Denormal 0x00000001 * 0x3F800000 -> 0x00000000.
- Range: 0x7F000000 * 0x7F000000 -> 0x7F800000, overflow=1. 0x00800000 * 0x00800000 -> 0x00000000, underflow=1.
- Backpressure: stream 5 back-to-back pairs, hold out_ready=0 for 4 cycles from the first out_valid -> in_ready drops, out_p stays stable, all 5 results arrive in order with matching tags, none lost or duplicated.
- Reset: assert rst for 1 cycle with 3 ops in flight -> out_valid=0 the next cycle and no stale result emitted; a new op after reset completes with 3-cycle latency.
